control_path_param: RTL and testbench

CONTROL_PATH_PARAM -- requirements
Module: control_path_param

---
 rtl/control_path_param.sv | 170 +++++++++++++++++
 tb/tb_control_path_param.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/control_path_param.sv
// Control path sequencing an s/y datapath through idle, enumerate, step and
// update regimes; regime, active, done and the two counters are the only state.
module control_path_param #(
  parameter int S_W        = 4,
  parameter int S_LAST     = 6,
  parameter int ENUM_STEP  = 2,
  parameter int ENUM_TICKS = 4,
  parameter int UPD_STAGES = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [1:0]     on,
  input  logic           start,
  input  logic           abort,
  input  logic [S_W-1:0] s_cur,
  output logic [1:0]     regime,
  output logic           active,
  output logic           busy,
  output logic           done,
  output logic [1:0]     y_select_next,
  output logic [S_W-1:0] s_step,
  output logic           y_en,
  output logic           s_en,
  output logic           y_store_x,
  output logic           s_add,
  output logic           s_zero
);

  localparam int TICK_W = (ENUM_TICKS > 1) ? $clog2(ENUM_TICKS) : 1;
  localparam int STG_W  = (UPD_STAGES > 1) ? $clog2(UPD_STAGES) : 1;

  localparam logic [TICK_W-1:0] TICK_MAX = TICK_W'(ENUM_TICKS - 1);
  localparam logic [TICK_W-1:0] TICK_ONE = TICK_W'(1);
  localparam logic [STG_W-1:0]  STG_MAX  = STG_W'(UPD_STAGES - 1);
  localparam logic [STG_W-1:0]  STG_TWO  = STG_W'(2);
  localparam logic [STG_W-1:0]  STG_ONE  = STG_W'(1);
  localparam logic [S_W-1:0]    W_LAST   = S_W'(S_LAST);
  localparam logic [S_W-1:0]    W_STEP   = S_W'(ENUM_STEP);
  localparam logic [S_W-1:0]    W_UNIT   = S_W'(1);

  typedef enum logic [1:0] {
    R0 = 2'd0,
    R1 = 2'd1,
    R2 = 2'd2,
    R3 = 2'd3
  } regime_t;

  regime_t           r_regime;
  logic              r_active;
  logic              r_done;
  logic [TICK_W-1:0] r_tick;
  logic [STG_W-1:0]  r_stage;

  logic w_tick_zero;
  logic w_at_last;
  logic w_abort_run;

  assign w_tick_zero = (r_tick == '0);
  assign w_at_last   = (s_cur == W_LAST);
  assign w_abort_run = abort && (r_regime != R0);

  assign regime = r_regime;
  assign active = r_active;
  assign done   = r_done;
  assign busy   = (r_regime != R0);

  always_comb begin
    y_select_next = 2'd0;
    s_step        = '0;
    y_en          = 1'b0;
    s_en          = 1'b0;
    y_store_x     = 1'b0;
    s_add         = 1'b0;
    s_zero        = 1'b0;
    case (r_regime)
      R1: begin
        if (r_active) begin
          s_step = W_STEP;
          s_add  = 1'b1;
          s_en   = w_tick_zero && !w_at_last;
        end else if (start) begin
          s_zero = 1'b1;
          s_en   = 1'b1;
        end
      end
      R2: begin
        s_en          = 1'b1;
        s_step        = W_UNIT;
        y_select_next = 2'd1;
        y_en          = w_at_last;
      end
      R3: begin
        // Top stage checked first so UPD_STAGES=3 has no middle stages.
        if (r_stage == STG_MAX) begin
          y_store_x = 1'b1;
          y_en      = 1'b1;
        end else if (r_stage >= STG_TWO) begin
          y_select_next = 2'd3;
          y_en          = 1'b1;
        end else if (r_stage == STG_ONE) begin
          s_en   = 1'b1;
          s_add  = 1'b1;
          s_step = W_UNIT;
        end
      end
      default: ;
    endcase
    if (abort) begin
      y_en      = 1'b0;
      s_en      = 1'b0;
      y_store_x = 1'b0;
      s_zero    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_regime <= R0;
      r_active <= 1'b0;
      r_done   <= 1'b0;
      r_tick   <= TICK_MAX;
      r_stage  <= STG_MAX;
    end else begin
      r_done <= 1'b0;
      if (w_abort_run) begin
        r_regime <= R0;
        r_active <= 1'b0;
        r_tick   <= TICK_MAX;
        r_stage  <= STG_MAX;
      end else begin
        case (r_regime)
          R0: begin
            if (!abort) r_regime <= regime_t'(on);
          end
          R1: begin
            if (r_active) begin
              if (!w_tick_zero) begin
                r_tick <= r_tick - TICK_ONE;
              end else if (!w_at_last) begin
                r_tick <= TICK_MAX;
              end else begin
                r_active <= 1'b0;
                r_regime <= R0;
                r_done   <= 1'b1;
                r_tick   <= TICK_MAX;
              end
            end else if (start) begin
              r_active <= 1'b1;
              r_tick   <= TICK_MAX;
            end
          end
          R2: begin
            if (!start) r_regime <= R0;
          end
          R3: begin
            if (r_stage == '0) begin
              r_regime <= R0;
              r_done   <= 1'b1;
              r_stage  <= STG_MAX;
            end else begin
              r_stage <= r_stage - STG_ONE;
            end
          end
          default: r_regime <= R0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_control_path_param.sv
// Directed bench for control_path_param: default instance plus a wider
// instance driven by a small s register model to check enumeration completion.
module tb_control_path_param;

  logic       clk;
  logic       rst;
  logic [1:0] on;
  logic       start;
  logic       abort;
  logic [3:0] s_cur;
  logic [1:0] regime;
  logic       active, busy, done;
  logic [1:0] y_select_next;
  logic [3:0] s_step;
  logic       y_en, s_en, y_store_x, s_add, s_zero;

  logic [1:0] on2;
  logic       start2, abort2;
  logic [5:0] s2;
  logic [1:0] regime2;
  logic       active2, busy2, done2;
  logic [1:0] ysel2;
  logic [5:0] s_step2;
  logic       y_en2, s_en2, y_store_x2, s_add2, s_zero2;

  int total = 0;
  int bad   = 0;

  control_path_param dut (
    .clk(clk), .rst(rst), .on(on), .start(start), .abort(abort), .s_cur(s_cur),
    .regime(regime), .active(active), .busy(busy), .done(done),
    .y_select_next(y_select_next), .s_step(s_step), .y_en(y_en), .s_en(s_en),
    .y_store_x(y_store_x), .s_add(s_add), .s_zero(s_zero)
  );

  control_path_param #(.S_W(6), .S_LAST(40), .ENUM_STEP(5), .ENUM_TICKS(2), .UPD_STAGES(4)) dut2 (
    .clk(clk), .rst(rst), .on(on2), .start(start2), .abort(abort2), .s_cur(s2),
    .regime(regime2), .active(active2), .busy(busy2), .done(done2),
    .y_select_next(ysel2), .s_step(s_step2), .y_en(y_en2), .s_en(s_en2),
    .y_store_x(y_store_x2), .s_add(s_add2), .s_zero(s_zero2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Datapath s register for the wide instance.
  initial s2 = 6'd0;
  always @(posedge clk) begin
    if (s_en2) begin
      if (s_zero2)     s2 <= 6'd0;
      else if (s_add2) s2 <= s2 + s_step2;
      else             s2 <= s2 - s_step2;
    end
  end

  // Strobe vector order: {y_en, s_en, y_store_x, s_add, s_zero}
  function automatic logic [4:0] stb();
    return {y_en, s_en, y_store_x, s_add, s_zero};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int cnt;
    int n;
    rst = 1'b0; on = 2'd0; start = 1'b0; abort = 1'b0; s_cur = 4'd0;
    on2 = 2'd0; start2 = 1'b0; abort2 = 1'b0;
    #3;
    chk("rst_regime", regime, 2'd0);
    chk("rst_active", active, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_strobes", stb(), 5'b00000);
    #9 rst = 1'b1;

    // abort in R0 blocks the regime request
    step(); on = 2'd1; abort = 1'b1; #1;
    chk("r0_strobes", stb(), 5'b00000);
    step(); abort = 1'b0; #1;
    chk("r0_abort_stay", regime, 2'd0);

    // enumeration: on=1 already applied, next edge enters R1
    step(); on = 2'd0; #1;
    chk("r1_regime", regime, 2'd1);
    chk("r1_busy", busy, 1'b1);
    chk("r1_wait_strobes", stb(), 5'b00000);
    start = 1'b1; #1;
    chk("r1_start_strobes", stb(), 5'b01001);
    step(); start = 1'b0; s_cur = 4'd0; #1;
    chk("r1_active", active, 1'b1);
    chk("r1_step", s_step, 4'd2);
    for (int k = 0; k < 2; k++) begin
      for (int t = 0; t < 3; t++) begin
        chk("r1_idle_tick", stb(), 5'b00010);
        step(); #1;
      end
      chk("r1_step_tick", stb(), 5'b01010);
      step(); #1;
    end
    for (int t = 0; t < 3; t++) begin
      chk("r1_idle_tick", stb(), 5'b00010);
      step(); #1;
    end
    s_cur = 4'd6; #1;
    chk("r1_last_strobes", stb(), 5'b00010);
    chk("r1_last_regime", regime, 2'd1);
    step(); #1;
    chk("r1_end_regime", regime, 2'd0);
    chk("r1_end_active", active, 1'b0);
    chk("r1_done", done, 1'b1);
    chk("r1_end_strobes", stb(), 5'b00000);
    step(); #1;
    chk("r1_done_pulse", done, 1'b0);

    // abort during R1 at tick 2
    on = 2'd1; s_cur = 4'd0;
    step(); on = 2'd0; start = 1'b1; #1;
    step(); start = 1'b0; #1;
    chk("ab1_tick3", stb(), 5'b00010);
    step(); abort = 1'b1; #1;
    chk("ab1_strobes", stb(), 5'b00010);
    step(); abort = 1'b0; #1;
    chk("ab1_regime", regime, 2'd0);
    chk("ab1_active", active, 1'b0);
    chk("ab1_done", done, 1'b0);

    // update regime
    on = 2'd3;
    step(); on = 2'd0; #1;
    chk("r3_regime", regime, 2'd3);
    chk("r3_stage3", stb(), 5'b10100);
    step(); #1;
    chk("r3_stage2", stb(), 5'b10000);
    chk("r3_stage2_sel", y_select_next, 2'd3);
    step(); #1;
    chk("r3_stage1", stb(), 5'b01010);
    chk("r3_stage1_step", s_step, 4'd1);
    step(); #1;
    chk("r3_stage0", stb(), 5'b00000);
    chk("r3_stage0_regime", regime, 2'd3);
    step(); #1;
    chk("r3_end_regime", regime, 2'd0);
    chk("r3_done", done, 1'b1);
    step(); #1;
    chk("r3_done_pulse", done, 1'b0);

    // step regime with start held 5 cycles
    on = 2'd2; start = 1'b1;
    step(); on = 2'd0;
    for (int c = 0; c < 5; c++) begin
      s_cur = 4'(4 + c); #1;
      chk("r2_strobes", stb(), (c == 2) ? 5'b11000 : 5'b01000);
      chk("r2_sel", y_select_next, 2'd1);
      chk("r2_step", s_step, 4'd1);
      chk("r2_regime", regime, 2'd2);
      step();
    end
    start = 1'b0; s_cur = 4'd0; #1;
    chk("r2_last_strobes", stb(), 5'b01000);
    step(); #1;
    chk("r2_end_regime", regime, 2'd0);
    chk("r2_no_done", done, 1'b0);

    // abort during R3 stage 2, then confirm stage reloaded
    on = 2'd3;
    step(); on = 2'd0; #1;
    step(); abort = 1'b1; #1;
    chk("ab3_strobes", stb(), 5'b00000);
    step(); abort = 1'b0; #1;
    chk("ab3_regime", regime, 2'd0);
    chk("ab3_done", done, 1'b0);
    on = 2'd3;
    step(); on = 2'd0; #1;
    chk("ab3_reload", stb(), 5'b10100);

    // asynchronous reset mid-R3
    step(); #1;
    chk("rst3_pre", stb(), 5'b10000);
    #1 rst = 1'b0; #1;
    chk("rst3_regime", regime, 2'd0);
    chk("rst3_strobes", stb(), 5'b00000);
    chk("rst3_sel", y_select_next, 2'd0);
    chk("rst3_busy", busy, 1'b0);
    #1 rst = 1'b1;
    step(); #1;
    chk("rst3_after", regime, 2'd0);
    chk("rst3_after_strobes", stb(), 5'b00000);

    // wide instance: 0..40 in steps of 5
    on2 = 2'd1;
    step(); on2 = 2'd0; start2 = 1'b1; #1;
    chk("w_start", {s_en2, s_zero2}, 2'b11);
    step(); start2 = 1'b0;
    cnt = 0;
    n = 0;
    while (n < 200) begin
      #1;
      if (done2) break;
      if (s_en2) cnt++;
      step();
      n++;
    end
    chk("w_done_seen", done2, 1'b1);
    chk("w_steps", cnt, 8);
    chk("w_s_final", s2, 6'd40);
    chk("w_regime", regime2, 2'd0);
    step(); #1;
    chk("w_done_pulse", done2, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
